arb_mux: RTL
============

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The block SHALL have parameter D_SIZE, default 2: width of one data channel in bits.
REQ-002 The block SHALL have parameter D_COUNT, default 3: number of input channels (2..16).
REQ-003 The block SHALL have parameter A_SIZE, default 2: width of out_sel, with 2**A_SIZE >= D_COUNT.
REQ-004 Port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_data, input, D_SIZE*D_COUNT bits: channel i occupies bits [i*D_SIZE +: D_SIZE].
REQ-007 Port in_valid, input, D_COUNT bits: per-channel valid.
REQ-008 Port in_ready, output, D_COUNT bits: per-channel ready; a beat transfers when in_valid[i] and in_ready[i] are both high.
REQ-009 Port out_data, output, D_SIZE bits: registered selected data.
REQ-010 Port out_sel, output, A_SIZE bits: index of the channel that sourced out_data.
REQ-011 Port out_valid, output, 1 bit: out_data and out_sel are valid.
REQ-012 Port out_ready, input, 1 bit: the downstream accepts the beat when out_valid and out_ready are both high.

Function
REQ-013 The output stage SHALL be a one-entry register, and it can load when (out_valid==0 || out_ready==1); this condition is "load_ok".
REQ-014 Grant SHALL be round-robin: search channels last_grant+1, last_grant+2, ..., wrapping modulo D_COUNT, and grant the first with in_valid high.
REQ-015 in_ready[i] SHALL be high only when load_ok and i is the granted channel; at most one in_ready bit is high in any cycle, and in_ready is combinational from in_valid, out_ready and state.
REQ-016 On a transfer, the output register SHALL capture the granted slice into out_data, the granted index into out_sel, and set out_valid=1; last_grant takes the granted index on the same edge.
REQ-017 Latency SHALL be 1 cycle from input transfer to out_valid.
REQ-018 Sustained throughput SHALL be 1 beat per cycle while out_ready is held high.
REQ-019 A simultaneous output drain and input transfer SHALL replace the register contents with no bubble.
REQ-020 If no channel is valid and the output drains, out_valid SHALL fall to 0 on the next edge.
REQ-021 Under backpressure (out_valid=1, out_ready=0), out_data, out_sel and out_valid SHALL hold, all in_ready bits SHALL be 0, and last_grant SHALL hold.
REQ-022 Wrap-around: when last_grant=D_COUNT-1, the search SHALL start at 0.
REQ-023 Only the granted channel's valid SHALL matter; in_valid on other channels has no effect on outputs.
REQ-024 in_valid dropping without a transfer SHALL be allowed; the arbiter re-evaluates every cycle.

Reset
REQ-025 While rst=1 at a clock edge, out_valid SHALL be 0, out_data SHALL be 0, out_sel SHALL be 0, and last_grant SHALL be D_COUNT-1, so channel 0 has first priority.
REQ-026 All in_ready bits SHALL be 0 while rst is high.
REQ-027 A beat held in the output register when reset asserts mid-operation SHALL be discarded.
REQ-028 The first grant after reset SHALL follow the reset priority.

Configuration
REQ-029 The feature SHALL be controlled by the macro ARB_MUX_LOCK_EN.
REQ-030 With ARB_MUX_LOCK_EN defined, the block SHALL add input port in_last (D_COUNT bits) and output port out_last (1 bit, registered with out_data, reset 0).
REQ-031 With ARB_MUX_LOCK_EN defined, the block SHALL run a two-state FSM, IDLE and LOCKED, reset to IDLE.
REQ-032 In IDLE, a transfer without in_last SHALL move the FSM to LOCKED on the granted channel, and a transfer with in_last SHALL stay in IDLE.
REQ-033 In LOCKED, only the locked channel SHALL be grantable, and a transfer with in_last SHALL return the FSM to IDLE.
REQ-034 Without ARB_MUX_LOCK_EN, the ports in_last and out_last and the FSM SHALL be absent, and arbitration SHALL occur every beat.

Verification
REQ-035 With D_SIZE=2, D_COUNT=3, out_ready=1, in_data=6'b10_01_00 and all in_valid high after reset, a bench SHALL see out_sel sequence 0,1,2,0 and out_data 0,1,2,0, starting one cycle after the first transfer.
REQ-036 With only in_valid[2] high and in_data[5:4]=3, a bench SHALL see in_ready=3'b100 and, next cycle, out_valid=1, out_data=3, out_sel=2.
REQ-037 With out_valid=1 and out_ready=0 held for 3 cycles, a bench SHALL see in_ready=0 and the outputs stable, and on out_ready=1 the next beat loads with no bubble.
REQ-038 Asserting rst while out_valid=1 SHALL give out_valid=0, out_data=0 and out_sel=0 on the next cycle, with the next grant going to channel 0.
REQ-039 With ARB_MUX_LOCK_EN, channel 1 sending 3 beats with in_last on the third while channels 0 and 2 are valid SHALL give out_sel=1,1,1 followed by 2.
REQ-040 With a single valid channel 0 and out_ready=1, a bench SHALL see a transfer every cycle and last_grant wrapping correctly.

Source files
------------

// File: rtl/arb_mux.sv
// Round-robin N:1 arbiter feeding a one-entry registered output stage.
// Define ARB_MUX_LOCK_EN to add in_last/out_last and hold the grant across multi-beat packets.
module arb_mux #(
    parameter int unsigned D_SIZE  = 2,
    parameter int unsigned D_COUNT = 3,
    parameter int unsigned A_SIZE  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [D_SIZE*D_COUNT-1:0] in_data,
    input  logic [D_COUNT-1:0]        in_valid,
    output logic [D_COUNT-1:0]        in_ready,
    output logic [D_SIZE-1:0]         out_data,
    output logic [A_SIZE-1:0]         out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef ARB_MUX_LOCK_EN
    ,
    input  logic [D_COUNT-1:0]        in_last,
    output logic                      out_last
`endif
);

    localparam int unsigned IdxW = (D_COUNT > 1) ? $clog2(D_COUNT) : 1;

    logic [D_COUNT-1:0][D_SIZE-1:0] slot_data;
    assign slot_data = in_data;

    logic [A_SIZE-1:0] last_q, last_d;
    logic [D_SIZE-1:0] data_q, data_d;
    logic [A_SIZE-1:0] sel_q, sel_d;
    logic              valid_q, valid_d;

    logic              load_ok;
    logic              locked;
    logic              grant_found;
    logic [A_SIZE-1:0] grant_idx;
    logic [D_SIZE-1:0] grant_data;
    logic              xfer;

`ifdef ARB_MUX_LOCK_EN
    typedef enum logic {StIdle, StLocked} state_e;
    state_e state_q, state_d;
    logic   last_q_flag, last_d_flag;
    logic   grant_last;

    assign locked = (state_q == StLocked);
`else
    assign locked = 1'b0;
`endif

    assign load_ok = !valid_q || out_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        if (locked) begin
            // While locked, last_q already names the locked channel.
            for (int unsigned i = 0; i < D_COUNT; i++) begin
                if (A_SIZE'(i) == last_q && in_valid[i[IdxW-1:0]]) begin
                    grant_found = 1'b1;
                    grant_idx   = A_SIZE'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < D_COUNT; i++) begin
                if (!grant_found && in_valid[i[IdxW-1:0]] && A_SIZE'(i) > last_q) begin
                    grant_found = 1'b1;
                    grant_idx   = A_SIZE'(i);
                end
            end
            for (int unsigned i = 0; i < D_COUNT; i++) begin
                if (!grant_found && in_valid[i[IdxW-1:0]] && A_SIZE'(i) <= last_q) begin
                    grant_found = 1'b1;
                    grant_idx   = A_SIZE'(i);
                end
            end
        end
    end

    assign xfer = !rst && load_ok && grant_found;

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < D_COUNT; i++) begin
            if (A_SIZE'(i) == grant_idx) begin
                in_ready[i[IdxW-1:0]] = xfer;
                grant_data            = slot_data[i[IdxW-1:0]];
            end
        end
    end

`ifdef ARB_MUX_LOCK_EN
    always_comb begin
        grant_last = 1'b0;
        for (int unsigned i = 0; i < D_COUNT; i++) begin
            if (A_SIZE'(i) == grant_idx) begin
                grant_last = in_last[i[IdxW-1:0]];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d_flag = last_q_flag;
        if (xfer) begin
            last_d_flag = grant_last;
            unique case (state_q)
                StIdle:   if (!grant_last) state_d = StLocked;
                StLocked: if (grant_last)  state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    assign out_last = last_q_flag;
`endif

    always_comb begin
        last_d  = last_q;
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (xfer) begin
            last_d  = grant_idx;
            data_d  = grant_data;
            sel_d   = grant_idx;
            valid_d = 1'b1;
        end else if (load_ok) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= A_SIZE'(D_COUNT - 1);
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
`ifdef ARB_MUX_LOCK_EN
            state_q     <= StIdle;
            last_q_flag <= 1'b0;
`endif
        end else begin
            last_q  <= last_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
`ifdef ARB_MUX_LOCK_EN
            state_q     <= state_d;
            last_q_flag <= last_d_flag;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule
